// File: rtl/rf_march_bist.sv
// rf_march_bist: on-chip March C- BIST for the 2W/3R register file.
// Owns RF write/read port A and masks write port B while a test runs.
module rf_march_bist #(
   parameter int                    ADDR_WIDTH = 5,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_LO    = 1,
   parameter int                    ADDR_HI    = 31,
   parameter logic [DATA_WIDTH-1:0] BG_PATTERN = '0,
   parameter int                    FCNT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  fail_o,
   output logic [ADDR_WIDTH-1:0] fail_addr_o,
   output logic [2:0]            fail_elem_o,
   output logic [FCNT_WIDTH-1:0] fail_cnt_o,
   input  logic [ADDR_WIDTH-1:0] func_raddr_a_i,
   input  logic [ADDR_WIDTH-1:0] func_waddr_a_i,
   input  logic [DATA_WIDTH-1:0] func_wdata_a_i,
   input  logic                  func_we_a_i,
   input  logic                  func_we_b_i,
   output logic [ADDR_WIDTH-1:0] rf_raddr_a_o,
   input  logic [DATA_WIDTH-1:0] rf_rdata_a_i,
   output logic [ADDR_WIDTH-1:0] rf_waddr_a_o,
   output logic [DATA_WIDTH-1:0] rf_wdata_a_o,
   output logic                  rf_we_a_o,
   output logic                  rf_we_b_o
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [ADDR_WIDTH-1:0] LO = ADDR_WIDTH'(ADDR_LO);
   localparam logic [ADDR_WIDTH-1:0] HI = ADDR_WIDTH'(ADDR_HI);

   state_t                  state_q, state_d;
   logic [2:0]              elem_q, elem_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    wr_ph_q, wr_ph_d;
   logic                    fail_q, fail_d;
   logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
   logic [2:0]              fail_elem_q, fail_elem_d;
   logic [FCNT_WIDTH-1:0]   fail_cnt_q, fail_cnt_d;
   logic                    down, two_op, is_rd, last_addr, mis;
   logic [DATA_WIDTH-1:0]   exp_rd, wpat;

   // e1..e4 are read-then-write pairs at one address; e0 is write-only, e5 read-only
   always_comb begin
      down        = elem_q == 3'd3 || elem_q == 3'd4;
      two_op      = elem_q != 3'd0 && elem_q != 3'd5;
      is_rd       = elem_q != 3'd0 && !wr_ph_q;
      last_addr   = addr_q == (down ? LO : HI);
      exp_rd      = (elem_q == 3'd2 || elem_q == 3'd4) ? ~BG_PATTERN : BG_PATTERN;
      wpat        = (elem_q == 3'd1 || elem_q == 3'd3) ? ~BG_PATTERN : BG_PATTERN;
      mis         = state_q == RUN && is_rd && rf_rdata_a_i != exp_rd;
      state_d     = state_q;
      elem_d      = elem_q;
      addr_d      = addr_q;
      wr_ph_d     = wr_ph_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_elem_d = fail_elem_q;
      fail_cnt_d  = fail_cnt_q;
      case (state_q)
         IDLE: if (start_i) begin
            state_d     = RUN;
            elem_d      = 3'd0;
            addr_d      = LO;
            wr_ph_d     = 1'b0;
            fail_d      = 1'b0;
            fail_addr_d = '0;
            fail_elem_d = '0;
            fail_cnt_d  = '0;
         end
         RUN: begin
            if (two_op && !wr_ph_q) wr_ph_d = 1'b1;
            else begin
               wr_ph_d = 1'b0;
               if (!last_addr) addr_d = down ? addr_q - 1'b1 : addr_q + 1'b1;
               else if (elem_q == 3'd5) state_d = DONE;
               else begin
                  elem_d = elem_q + 3'd1;
                  addr_d = (elem_q == 3'd2 || elem_q == 3'd3) ? HI : LO;
               end
            end
            if (mis) begin
               fail_cnt_d = &fail_cnt_q ? fail_cnt_q : fail_cnt_q + 1'b1;
               if (!fail_q) begin
                  fail_d      = 1'b1;
                  fail_addr_d = addr_q;
                  fail_elem_d = elem_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         elem_q      <= '0;
         addr_q      <= LO;
         wr_ph_q     <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= '0;
         fail_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         addr_q      <= addr_d;
         wr_ph_q     <= wr_ph_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_elem_q <= fail_elem_d;
         fail_cnt_q  <= fail_cnt_d;
      end
   end

   assign busy_o       = state_q == RUN;
   assign done_o       = state_q == DONE;
   assign fail_o       = fail_q;
   assign fail_addr_o  = fail_addr_q;
   assign fail_elem_o  = fail_elem_q;
   assign fail_cnt_o   = fail_cnt_q;
   assign rf_raddr_a_o = busy_o ? addr_q : func_raddr_a_i;
   assign rf_waddr_a_o = busy_o ? addr_q : func_waddr_a_i;
   assign rf_wdata_a_o = busy_o ? wpat : func_wdata_a_i;
   assign rf_we_a_o    = busy_o ? !is_rd : func_we_a_i;
   assign rf_we_b_o    = busy_o ? 1'b0 : func_we_b_i;
endmodule

// File: tb/tb_rf_march_bist.sv
// tb_rf_march_bist: randomized fault-injection bench with an op-level scoreboard.
module tb_rf_march_bist;
   localparam int AW = 5, DW = 32, LO = 1, HI = 31, FW = 4, N = HI - LO + 1;
   localparam logic [DW-1:0] BG = 32'hA5C3_0F96;

   logic clk, rst_n, start_i, busy_o, done_o, fail_o;
   logic [AW-1:0] fail_addr_o, func_raddr_a_i, func_waddr_a_i, rf_raddr_a_o, rf_waddr_a_o;
   logic [2:0] fail_elem_o;
   logic [FW-1:0] fail_cnt_o;
   logic [DW-1:0] func_wdata_a_i, rf_rdata_a_i, rf_wdata_a_o;
   logic func_we_a_i, func_we_b_i, rf_we_a_o, rf_we_b_o;

   rf_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_LO(LO), .ADDR_HI(HI),
                   .BG_PATTERN(BG), .FCNT_WIDTH(FW)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
      .fail_o(fail_o), .fail_addr_o(fail_addr_o), .fail_elem_o(fail_elem_o),
      .fail_cnt_o(fail_cnt_o), .func_raddr_a_i(func_raddr_a_i),
      .func_waddr_a_i(func_waddr_a_i), .func_wdata_a_i(func_wdata_a_i),
      .func_we_a_i(func_we_a_i), .func_we_b_i(func_we_b_i), .rf_raddr_a_o(rf_raddr_a_o),
      .rf_rdata_a_i(rf_rdata_a_i), .rf_waddr_a_o(rf_waddr_a_o), .rf_wdata_a_o(rf_wdata_a_o),
      .rf_we_a_o(rf_we_a_o), .rf_we_b_o(rf_we_b_o));

   // RF model: stuck-at faults applied on the read path, address 0 not writable
   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] sa1 [2**AW];
   logic [DW-1:0] sa0 [2**AW];
   assign rf_rdata_a_i = (mem[rf_raddr_a_o] | sa1[rf_raddr_a_o]) & ~sa0[rf_raddr_a_o];
   always @(posedge clk) if (rf_we_a_o && rf_waddr_a_o != '0) mem[rf_waddr_a_o] <= rf_wdata_a_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {logic w; logic [AW-1:0] a; logic [DW-1:0] d;} op_t;
   typedef struct packed {logic f; logic [AW-1:0] a; logic [2:0] e; logic [FW-1:0] c;} res_t;
   op_t  opq[$];
   res_t resq[$];
   res_t last_res, mres;
   op_t  mop;
   int   checks = 0, errors = 0, busy_cnt = 0;
   bit   done_seen;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   // March C- as an element table, run against a shadow of the faulty RF
   task automatic expect_run();
      logic [DW-1:0] sh [2**AW];
      logic [DW-1:0] rv, wv, got;
      res_t r;
      int a;
      r = '0;
      for (int e = 0; e < 6; e++)
         for (int k = 0; k < N; k++) begin
            a = (e == 3 || e == 4) ? HI - k : LO + k;
            if (e > 0) begin
               rv = (e % 2 == 0) ? ~BG : BG;
               opq.push_back({1'b0, AW'(a), rv});
               got = (sh[a] | sa1[a]) & ~sa0[a];
               if (got !== rv) begin
                  if (!r.f) begin
                     r.f = 1'b1;
                     r.a = AW'(a);
                     r.e = 3'(e);
                  end
                  if (r.c != '1) r.c = r.c + 1'b1;
               end
            end
            if (e < 5) begin
               wv = (e % 2 == 1) ? ~BG : BG;
               opq.push_back({1'b1, AW'(a), wv});
               sh[a] = wv;
            end
         end
      resq.push_back(r);
   endtask

   task automatic set_fault(input int kind);
      for (int i = 0; i < 2**AW; i++) begin
         sa1[i] = '0;
         sa0[i] = (kind == 3) ? '1 : '0;
      end
      if (kind == 1) sa1[7][3] = 1'b1;
      if (kind == 2) sa0[31][0] = 1'b1;
      if (kind >= 4) begin
         sa1[$urandom_range(HI, LO)] = DW'(1) << $urandom_range(DW - 1, 0);
         if ($urandom_range(1, 0) == 1) sa0[$urandom_range(HI, LO)] = DW'(1) << $urandom_range(DW - 1, 0);
      end
   endtask

   task automatic rand_func();
      func_raddr_a_i = AW'($urandom);
      func_waddr_a_i = AW'($urandom);
      func_wdata_a_i = $urandom;
      func_we_a_i    = 1'($urandom);
      func_we_b_i    = 1'($urandom);
   endtask

   task automatic check_mirror(input string tag);
      chk({tag, "_raddr"}, rf_raddr_a_o, func_raddr_a_i);
      chk({tag, "_waddr"}, rf_waddr_a_o, func_waddr_a_i);
      chk({tag, "_wdata"}, rf_wdata_a_o, func_wdata_a_i);
      chk({tag, "_we_a"}, rf_we_a_o, func_we_a_i);
      chk({tag, "_we_b"}, rf_we_b_o, func_we_b_i);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, busy_o, 1'b0);
      chk({tag, "_done"}, done_o, 1'b0);
      chk({tag, "_fail"}, fail_o, 1'b0);
      chk({tag, "_fail_addr"}, fail_addr_o, '0);
      chk({tag, "_fail_elem"}, fail_elem_o, '0);
      chk({tag, "_fail_cnt"}, fail_cnt_o, '0);
   endtask

   task automatic run_test(input int kind, input bit hold);
      set_fault(kind);
      expect_run();
      done_seen = 1'b0;
      @(posedge clk); #1 start_i = 1'b1;
      if (!hold) begin
         @(posedge clk); #1 start_i = 1'b0;
      end
      for (int i = 0; i < 10 * N + 20 && !done_seen; i++) begin
         @(posedge clk); #1;
         rand_func();
         func_we_a_i = 1'b1;
         func_we_b_i = 1'b1;
      end
      start_i = 1'b0;
      if (!done_seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done_o within %0d cycles (kind %0d)", 10 * N + 20, kind);
      end
      @(negedge clk);
      chk("done_pulse", done_o, 1'b0);
      chk("idle_busy", busy_o, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("hold_fail", fail_o, last_res.f);
      chk("hold_cnt", fail_cnt_o, last_res.c);
      chk("hold_addr", fail_addr_o, last_res.a);
   endtask

   // monitor: every busy cycle must be the next scheduled op; done closes the run
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (busy_o) begin
            busy_cnt++;
            chk("we_b_masked", rf_we_b_o, 1'b0);
            if (opq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_op: busy with no op expected at %0t", $time);
            end else begin
               mop = opq.pop_front();
               chk("op_we", rf_we_a_o, mop.w);
               chk("op_addr", mop.w ? rf_waddr_a_o : rf_raddr_a_o, mop.a);
               if (mop.w) chk("op_wdata", rf_wdata_a_o, mop.d);
            end
         end
         if (done_o) begin
            done_seen = 1'b1;
            chk("busy_cycles", busy_cnt, 10 * N);
            chk("ops_left", opq.size(), 0);
            busy_cnt = 0;
            if (resq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_done: done_o with no run expected at %0t", $time);
            end else begin
               mres = resq.pop_front();
               last_res = mres;
               chk("res_fail", fail_o, mres.f);
               chk("res_addr", fail_addr_o, mres.a);
               chk("res_elem", fail_elem_o, mres.e);
               chk("res_cnt", fail_cnt_o, mres.c);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      start_i = 1'b0;
      rand_func();
      set_fault(0);
      for (int i = 0; i < 2**AW; i++) mem[i] = $urandom;
      #12;
      check_reset_vals("por");
      check_mirror("por");
      @(negedge clk) rst_n = 1'b1;
      repeat (6) begin
         @(posedge clk); #1 rand_func();
         #1 check_mirror("idle");
      end
      run_test(0, 1'b1);
      run_test(1, 1'b0);
      run_test(2, 1'b0);
      run_test(3, 1'b0);
      repeat (4) run_test(4, 1'($urandom));
      set_fault(3);
      expect_run();
      @(posedge clk); #1 start_i = 1'b1;
      repeat (100) @(posedge clk);
      #2 chk("pre_reset_fail", fail_o, 1'b1);
      rst_n = 1'b0;
      opq.delete();
      resq.delete();
      busy_cnt = 0;
      rand_func();
      func_we_b_i = 1'b1;
      #1 check_reset_vals("midrun");
      check_mirror("midrun");
      start_i = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      run_test(0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rf_march_bist.md
Name: rf_march_bist

Overview:
- Self-contained memory BIST engine for the 2W/3R core register file. It replaces the external BIST collar interface with an on-chip March C- sequencer.
- It muxes write port A and read port A between functional and test traffic, and masks write port B during test.
- It compares read data on the fly and captures the first failing address and element, plus a saturating fail count.
- Fully parametrised in data width, address width, tested address window and data background.

Parameters:
ADDR_WIDTH, 5, register file address width
DATA_WIDTH, 32, register file data width
ADDR_LO, 1, first tested address (address 0 is not writable, so never tested)
ADDR_HI, 31, last tested address; ADDR_LO <= ADDR_HI < 2**ADDR_WIDTH
BG_PATTERN, 0 (DATA_WIDTH bits), data background written as "0"; "1" is ~BG_PATTERN
FCNT_WIDTH, 8, width of saturating fail counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  start test; sampled in IDLE only
busy_o  out  1  test running; RF ports under BIST control
done_o  out  1  one-cycle pulse at test end
fail_o  out  1  sticky: at least one mismatch since last start
fail_addr_o  out  ADDR_WIDTH  address of first mismatch
fail_elem_o  out  3  March element index (0..5) of first mismatch
fail_cnt_o  out  FCNT_WIDTH  mismatch count, saturating
func_raddr_a_i  in  ADDR_WIDTH  functional read address A
func_waddr_a_i  in  ADDR_WIDTH  functional write address A
func_wdata_a_i  in  DATA_WIDTH  functional write data A
func_we_a_i  in  1  functional write enable A
func_we_b_i  in  1  functional write enable B
rf_raddr_a_o  out  ADDR_WIDTH  to RF read port A
rf_rdata_a_i  in  DATA_WIDTH  from RF read port A (combinational read)
rf_waddr_a_o  out  ADDR_WIDTH  to RF write port A
rf_wdata_a_o  out  DATA_WIDTH  to RF write port A
rf_we_a_o  out  1  to RF write enable A
rf_we_b_o  out  1  to RF write enable B (forced 0 while busy)

Behaviour:
- Reset (async): state IDLE; busy_o=0, done_o=0, fail_o=0, fail_addr_o=0, fail_elem_o=0, fail_cnt_o=0. BIST drives no write.
- Port muxing: when busy_o=0, all rf_* outputs equal the corresponding func_* inputs. When busy_o=1, rf_* are driven by the sequencer and rf_we_b_o=0.
- FSM states:
  - IDLE: start_i=1 moves to RUN at the next edge and clears fail_o, fail_addr_o, fail_elem_o and fail_cnt_o. start_i while RUN or DONE is ignored.
  - RUN: executes one March operation per cycle. After the final operation, moves to DONE.
  - DONE: one cycle with done_o=1 and busy_o=0, then moves to IDLE.
- March C- elements, with N = ADDR_HI-ADDR_LO+1:
  - e0 up(w0)
  - e1 up(r0,w1)
  - e2 up(r1,w0)
  - e3 down(r0,w1)
  - e4 down(r1,w0)
  - e5 up(r0)
- Up order runs ADDR_LO..ADDR_HI; down order runs ADDR_HI..ADDR_LO. Address counter wraps only at element boundaries, never outside the window.
- Per-operation cycles: the read op drives rf_raddr_a_o=addr and rf_we_a_o=0. The write op drives rf_waddr_a_o=addr, rf_wdata_a_o=pattern and rf_we_a_o=1; the write commits at the cycle's closing edge. A read and its write are separate, consecutive cycles at the same address.
- Latency: busy_o is high for exactly 10*N cycles. done_o asserts in the cycle after the last e5 read.
- Compare: in each read cycle, rf_rdata_a_i is compared against the expected value (BG_PATTERN for r0, ~BG_PATTERN for r1). A mismatch registers at the closing edge:
  - fail_cnt_o increments, saturating at all-ones.
  - On the first mismatch only, fail_o goes to 1 and fail_addr_o/fail_elem_o are captured.
- Fail results hold through DONE and IDLE until the next accepted start.
- Reset mid-run: immediate return to IDLE per the reset values above; RF contents are undefined afterwards.
- Degenerate window: with N=1, the sequence still runs 10 cycles.

Test Plan:
- Defaults, fault-free RF model, start_i pulse -> busy_o high for 310 cycles; done_o one pulse; fail_o=0, fail_cnt_o=0; first write addr 1 data 0x00000000, last read addr 31.
- Stuck-at-1 on bit 3 of addr 7 -> mismatches in e1, e3 and e5 -> fail_o=1, fail_addr_o=7, fail_elem_o=1, fail_cnt_o=3.
- Stuck-at-0 on bit 0 of addr 31, BG_PATTERN=0x55555555 -> first mismatch in e1 (r0 expects 0x55555555) -> fail_addr_o=31, fail_elem_o=1, fail_cnt_o=3 (e1, e3, e5 all read the background).
- All cells stuck 0x0, FCNT_WIDTH=4 -> fail_cnt_o saturates at 15; fail_addr_o=1, fail_elem_o=2.
- start_i held high during RUN, then rst_n low at cycle 100 -> second start ignored; all outputs at reset values immediately; rf_* follow func_* and rf_we_b_o=func_we_b_i.
- Functional traffic with busy_o=0 -> rf outputs mirror func inputs every cycle. During busy_o=1, func_we_a_i=1 and func_we_b_i=1 cause no functional write.
